// File: rtl/store_align_unit.sv
// Store alignment unit: turns an SB/SH/SW request into one or two lane-aligned
// word writes on a req/ack memory bus, with done/error pulses back to the pipe.
module store_align_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        st_done,
  output logic        st_err
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  state_t      r_state;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_hi_addr;
  logic [31:0] r_hi_wdata;
  logic [3:0]  r_hi_be;

  logic        w_legal;
  logic [31:0] w_sized;
  logic [3:0]  w_nmask;
  logic [63:0] w_shifted;
  logic [7:0]  w_mask;
  logic [31:0] w_lo_addr;
  logic        w_accept;

  always_comb begin
    w_legal = 1'b1;
    w_sized = 32'h0;
    w_nmask = 4'h0;
    case (st_funct3)
      3'b000:  begin w_sized = {24'h0, st_data[7:0]};  w_nmask = 4'b0001; end
      3'b001:  begin w_sized = {16'h0, st_data[15:0]}; w_nmask = 4'b0011; end
      3'b010:  begin w_sized = st_data;                w_nmask = 4'b1111; end
      default: w_legal = 1'b0;
    endcase
  end

  // The 64-bit view spans the addressed word and the next; the upper half is
  // nonzero only for stores that cross a word boundary.
  assign w_shifted = {32'h0, w_sized} << {st_addr[1:0], 3'b000};
  assign w_mask    = {4'h0, w_nmask} << st_addr[1:0];
  assign w_lo_addr = {st_addr[31:2], 2'b00};
  assign w_accept  = st_valid && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= 4'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_hi_addr   <= 32'h0;
      r_hi_wdata  <= 32'h0;
      r_hi_be     <= 4'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_state     <= WR_LO;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= w_lo_addr;
              r_mem_wdata <= w_shifted[31:0];
              r_mem_be    <= w_mask[3:0];
              r_hi_addr   <= w_lo_addr + 32'd4;
              r_hi_wdata  <= w_shifted[63:32];
              r_hi_be     <= w_mask[7:4];
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        WR_LO: begin
          if (mem_ack) begin
            if (r_hi_be != 4'h0) begin
              // req stays high; only the word fields switch to the high half
              r_state     <= WR_HI;
              r_mem_addr  <= r_hi_addr;
              r_mem_wdata <= r_hi_wdata;
              r_mem_be    <= r_hi_be;
            end else begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        WR_HI: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign st_ready  = (r_state == IDLE);
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign st_done   = r_done;
  assign st_err    = r_err;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: hand-computed bus fields and pulse timing.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_done;
  logic        st_err;

  int checks = 0;
  int failures = 0;

  store_align_unit dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .st_done(st_done), .st_err(st_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and samples live 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
    step();
    st_valid = 1'b0; st_addr = 32'hX; st_data = 32'hX; st_funct3 = 3'bx;
  endtask

  task automatic bus(input string tag, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd);
    chk({tag, ".req"},   {31'h0, mem_req}, 32'h1);
    chk({tag, ".addr"},  mem_addr, a);
    chk({tag, ".be"},    {28'h0, mem_be}, {28'h0, be});
    chk({tag, ".wdata"}, mem_wdata, wd);
    chk({tag, ".done"},  {31'h0, st_done}, 32'h0);
  endtask

  task automatic ack_now();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
    st_funct3 = 3'b000; mem_ack = 1'b1;
    step(); step();
    chk("rst.ready", {31'h0, st_ready}, 32'h1);
    chk("rst.req",   {31'h0, mem_req}, 32'h0);
    chk("rst.addr",  mem_addr, 32'h0);
    chk("rst.wdata", mem_wdata, 32'h0);
    chk("rst.be",    {28'h0, mem_be}, 32'h0);
    chk("rst.done",  {31'h0, st_done}, 32'h0);
    chk("rst.err",   {31'h0, st_err}, 32'h0);
    rst_n = 1'b1;
    step();
    // ack held high while idle must not produce anything
    chk("idle_ack.done", {31'h0, st_done}, 32'h0);
    mem_ack = 1'b0;

    // SB byte 3
    issue(32'h0000_1003, 32'hAABB_CCDD, 3'b000);
    chk("sb.ready", {31'h0, st_ready}, 32'h0);
    bus("sb", 32'h0000_1000, 4'b1000, 32'hDD00_0000);
    ack_now();
    chk("sb.done",  {31'h0, st_done}, 32'h1);
    chk("sb.req0",  {31'h0, mem_req}, 32'h0);
    chk("sb.ready2", {31'h0, st_ready}, 32'h1);

    // SH accepted back-to-back in the st_done cycle
    issue(32'h0000_2002, 32'h0000_1234, 3'b001);
    bus("sh", 32'h0000_2000, 4'b1100, 32'h1234_0000);
    ack_now();
    chk("sh.done", {31'h0, st_done}, 32'h1);
    step();
    chk("sh.done_once", {31'h0, st_done}, 32'h0);

    // Misaligned SW split across two words
    issue(32'h0000_3001, 32'h1122_3344, 3'b010);
    bus("sw_lo", 32'h0000_3000, 4'b1110, 32'h2233_4400);
    ack_now();
    bus("sw_hi", 32'h0000_3004, 4'b0001, 32'h0000_0011);
    ack_now();
    chk("sw.done", {31'h0, st_done}, 32'h1);
    chk("sw.req0", {31'h0, mem_req}, 32'h0);
    step();
    chk("sw.done_once", {31'h0, st_done}, 32'h0);

    // Wrap-around SW with 3-cycle ack delay on each word
    issue(32'hFFFF_FFFE, 32'hCAFE_BABE, 3'b010);
    for (int i = 0; i < 3; i++) begin
      bus("wrap_lo", 32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000);
      step();
    end
    bus("wrap_lo", 32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000);
    ack_now();
    for (int i = 0; i < 3; i++) begin
      bus("wrap_hi", 32'h0000_0000, 4'b0011, 32'h0000_CAFE);
      step();
    end
    bus("wrap_hi", 32'h0000_0000, 4'b0011, 32'h0000_CAFE);
    ack_now();
    chk("wrap.done", {31'h0, st_done}, 32'h1);
    step();

    // Illegal funct3 values
    issue(32'h0000_0010, 32'h1111_1111, 3'b011);
    chk("ill3.err",   {31'h0, st_err}, 32'h1);
    chk("ill3.req",   {31'h0, mem_req}, 32'h0);
    chk("ill3.ready", {31'h0, st_ready}, 32'h1);
    chk("ill3.done",  {31'h0, st_done}, 32'h0);
    step();
    chk("ill3.err_once", {31'h0, st_err}, 32'h0);
    issue(32'h0000_0020, 32'h2222_2222, 3'b100);
    chk("ill4.err", {31'h0, st_err}, 32'h1);
    chk("ill4.req", {31'h0, mem_req}, 32'h0);
    step();
    chk("ill4.err_once", {31'h0, st_err}, 32'h0);
    chk("ill4.req2", {31'h0, mem_req}, 32'h0);

    // Reset while waiting for the high-word ack
    issue(32'h0000_4002, 32'h5566_7788, 3'b010);
    bus("rmid_lo", 32'h0000_4000, 4'b1100, 32'h7788_0000);
    ack_now();
    bus("rmid_hi", 32'h0000_4004, 4'b0011, 32'h0000_5566);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rmid.req",   {31'h0, mem_req}, 32'h0);
    chk("rmid.ready", {31'h0, st_ready}, 32'h1);
    chk("rmid.addr",  mem_addr, 32'h0);
    chk("rmid.be",    {28'h0, mem_be}, 32'h0);
    chk("rmid.wdata", mem_wdata, 32'h0);
    chk("rmid.done",  {31'h0, st_done}, 32'h0);
    chk("rmid.err",   {31'h0, st_err}, 32'h0);
    step();
    chk("rmid.done2", {31'h0, st_done}, 32'h0);

    // Aligned SW after the aborted store
    issue(32'h0000_5000, 32'hDEAD_BEEF, 3'b010);
    bus("post", 32'h0000_5000, 4'b1111, 32'hDEAD_BEEF);
    step();
    bus("post_hold", 32'h0000_5000, 4'b1111, 32'hDEAD_BEEF);
    ack_now();
    chk("post.done", {31'h0, st_done}, 32'h1);
    chk("post.req0", {31'h0, mem_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
